// File: rtl/axi_dma_tile_sched.sv
// rtl/axi_dma_tile_sched.sv - multi-tile job sequencer for axi_dma command ports
// Optional watchdog and ERR state: `define TILE_SCHED_TIMEOUT_EN
module axi_dma_tile_sched #(
  parameter int ADDR_WIDTH     = 64,
  parameter int TILE_CNT_W     = 16,
  parameter int IDLE_GUARD     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [ADDR_WIDTH-1:0] rd_stride,
  input  logic [ADDR_WIDTH-1:0] wr_stride,
  input  logic [31:0]           tile_rd_len,
  input  logic [31:0]           tile_wr_len,
  output logic [ADDR_WIDTH-1:0] axi_read_start_addr,
  output logic [ADDR_WIDTH-1:0] axi_write_start_addr,
  output logic [31:0]           axi_read_length,
  output logic [31:0]           axi_write_length,
  output logic                  init_read,
  output logic                  init_write,
  input  logic                  axi_read_start_ready,
  input  logic                  axi_write_start_ready,
  input  logic                  axi_dma_rd_idle,
  input  logic                  axi_dma_wr_idle,
  output logic                  busy,
  output logic                  done,
  output logic [TILE_CNT_W-1:0] tiles_done,
  output logic                  error
);

  localparam int GUARD_W = $clog2(IDLE_GUARD + 1);

`ifdef TILE_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_WR, S_ISSUE_RD, S_WAIT, S_NEXT, S_FIN, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_WR, S_ISSUE_RD, S_WAIT, S_NEXT, S_FIN
  } state_t;
`endif

  state_t                state;
  logic [TILE_CNT_W-1:0] num_tiles_q;
  logic [ADDR_WIDTH-1:0] rd_stride_q;
  logic [ADDR_WIDTH-1:0] wr_stride_q;
  logic [GUARD_W-1:0]    guard;
  logic                  wr_armed;

  // The write command is held back one cycle after entering ISSUE_WR so the
  // registered address is stable the cycle before the strobe; the strobe is
  // qualified by ready so it only ever lands in an accepting cycle.
  assign init_write = wr_armed && axi_write_start_ready && (state == S_ISSUE_WR);
  assign init_read  = (state == S_ISSUE_RD) && axi_read_start_ready;

`ifdef TILE_SCHED_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt;
  logic        wd_expire;
  assign wd_expire = (state != S_IDLE) && (state != S_ERR) && (wd_cnt == WD_LAST);
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                <= S_IDLE;
      num_tiles_q          <= '0;
      rd_stride_q          <= '0;
      wr_stride_q          <= '0;
      guard                <= '0;
      wr_armed             <= 1'b0;
      axi_read_start_addr  <= '0;
      axi_write_start_addr <= '0;
      axi_read_length      <= '0;
      axi_write_length     <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      tiles_done           <= '0;
`ifdef TILE_SCHED_TIMEOUT_EN
      wd_cnt               <= '0;
      error                <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      wr_armed <= (state == S_ISSUE_WR) && !init_write;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_tiles_q          <= num_tiles;
            rd_stride_q          <= rd_stride;
            wr_stride_q          <= wr_stride;
            axi_read_start_addr  <= rd_base;
            axi_write_start_addr <= wr_base;
            axi_read_length      <= tile_rd_len;
            axi_write_length     <= tile_wr_len;
            tiles_done           <= '0;
            busy                 <= 1'b1;
`ifdef TILE_SCHED_TIMEOUT_EN
            error                <= 1'b0;
`endif
            state <= (num_tiles == '0) ? S_FIN : S_ISSUE_WR;
          end
        end
        S_ISSUE_WR: if (init_write) state <= S_ISSUE_RD;
        S_ISSUE_RD: begin
          if (init_read) begin
            guard <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Idle flags may lag the command by a cycle or two; trust them only
          // once the guard has elapsed.
          if (guard != GUARD_W'(IDLE_GUARD)) guard <= guard + 1'b1;
          else if (axi_dma_rd_idle && axi_dma_wr_idle) state <= S_NEXT;
        end
        S_NEXT: begin
          tiles_done           <= tiles_done + 1'b1;
          axi_read_start_addr  <= axi_read_start_addr + rd_stride_q;
          axi_write_start_addr <= axi_write_start_addr + wr_stride_q;
          state <= ((tiles_done + 1'b1) == num_tiles_q) ? S_FIN : S_ISSUE_WR;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef TILE_SCHED_TIMEOUT_EN
        S_ERR: begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
`ifdef TILE_SCHED_TIMEOUT_EN
      wd_cnt <= (state == S_IDLE || state == S_NEXT) ? '0 : wd_cnt + 1'b1;
      if (wd_expire) state <= S_ERR;
`endif
    end
  end

endmodule

// File: tb/tb_axi_dma_tile_sched.sv
// tb/tb_axi_dma_tile_sched.sv - directed self-checking bench for axi_dma_tile_sched
module tb_axi_dma_tile_sched;
  logic        clk = 1'b0;
  logic        rstn, start;
  logic [15:0] num_tiles;
  logic [63:0] rd_base, wr_base, rd_stride, wr_stride;
  logic [31:0] tile_rd_len, tile_wr_len;
  logic [63:0] axi_read_start_addr, axi_write_start_addr;
  logic [31:0] axi_read_length, axi_write_length;
  logic        init_read, init_write;
  logic        axi_read_start_ready, axi_write_start_ready;
  logic        axi_dma_rd_idle, axi_dma_wr_idle;
  logic        busy, done, error;
  logic [15:0] tiles_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_dma_tile_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles),
    .rd_base(rd_base), .wr_base(wr_base), .rd_stride(rd_stride), .wr_stride(wr_stride),
    .tile_rd_len(tile_rd_len), .tile_wr_len(tile_wr_len),
    .axi_read_start_addr(axi_read_start_addr), .axi_write_start_addr(axi_write_start_addr),
    .axi_read_length(axi_read_length), .axi_write_length(axi_write_length),
    .init_read(init_read), .init_write(init_write),
    .axi_read_start_ready(axi_read_start_ready), .axi_write_start_ready(axi_write_start_ready),
    .axi_dma_rd_idle(axi_dma_rd_idle), .axi_dma_wr_idle(axi_dma_wr_idle),
    .busy(busy), .done(done), .tiles_done(tiles_done), .error(error)
  );

  // Command log built on the falling edge.
  logic [63:0] wr_q[$], rd_q[$];
  logic [31:0] wlen_q[$], rlen_q[$];
  int          wc_q[$], rc_q[$];
  logic [63:0] order_bits;
  int          cyc = 0, done_cnt = 0, viol = 0;
  logic        prev_w = 1'b0, prev_r = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (init_write) begin
      wr_q.push_back(axi_write_start_addr);
      wlen_q.push_back(axi_write_length);
      wc_q.push_back(cyc);
      order_bits = {order_bits[62:0], 1'b0};
      if (!axi_write_start_ready || prev_w) viol = viol + 1;
    end
    if (init_read) begin
      rd_q.push_back(axi_read_start_addr);
      rlen_q.push_back(axi_read_length);
      rc_q.push_back(cyc);
      order_bits = {order_bits[62:0], 1'b1};
      if (!axi_read_start_ready || prev_r) viol = viol + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    prev_w = init_write;
    prev_r = init_read;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete(); rd_q.delete(); wlen_q.delete(); rlen_q.delete();
    wc_q.delete(); rc_q.delete();
    order_bits = 64'h1;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit ok;

  initial begin
    rstn = 1'b0; start = 1'b0; num_tiles = '0;
    rd_base = '0; wr_base = '0; rd_stride = '0; wr_stride = '0;
    tile_rd_len = '0; tile_wr_len = '0;
    axi_read_start_ready = 1'b1; axi_write_start_ready = 1'b1;
    axi_dma_rd_idle = 1'b1; axi_dma_wr_idle = 1'b1;
    order_bits = 64'h1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_init", {init_write, init_read}, 0);
    chk("rst_tiles", tiles_done, 0);
    chk("rst_addr", axi_read_start_addr | axi_write_start_addr, 0);
    chk("rst_len", {axi_read_length, axi_write_length}, 0);
    chk("rst_error", error, 0);
    rstn = 1'b1;
    step();

    // Three-tile job with strided addresses.
    clear_log();
    num_tiles = 3; rd_base = 64'h0; rd_stride = 64'h1000;
    wr_base = 64'h20000; wr_stride = 64'h1000;
    tile_rd_len = 32'h1000; tile_wr_len = 32'h1000;
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_no_early_wr", init_write, 0);
    step();
    chk("t1_first_wr", init_write, 1);
    chk("t1_first_wr_addr", axi_write_start_addr, 64'h20000);
    wait_done(300, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_tiles_done", tiles_done, 3);
    repeat (5) step();
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_wr_cnt", wr_q.size(), 3);
    chk("t1_rd_cnt", rd_q.size(), 3);
    if (wr_q.size() == 3 && rd_q.size() == 3) begin
      chk("t1_wr0", wr_q[0], 64'h20000);
      chk("t1_wr1", wr_q[1], 64'h21000);
      chk("t1_wr2", wr_q[2], 64'h22000);
      chk("t1_rd0", rd_q[0], 64'h0);
      chk("t1_rd1", rd_q[1], 64'h1000);
      chk("t1_rd2", rd_q[2], 64'h2000);
      chk("t1_rlen", rlen_q[2], 32'h1000);
      chk("t1_wlen", wlen_q[1], 32'h1000);
      chk("t1_gap_min", (wc_q[1] - rc_q[0]) >= 6, 1);
    end
    chk("t1_order", order_bits, 64'b1010101);

    // Empty job.
    clear_log();
    num_tiles = 0;
    pulse_start();
    chk("t2_busy", busy, 1);
    chk("t2_done_early", done, 0);
    step();
    chk("t2_done", done, 1);
    chk("t2_busy_off", busy, 0);
    chk("t2_tiles", tiles_done, 0);
    repeat (3) step();
    chk("t2_no_cmds", wr_q.size() + rd_q.size(), 0);
    chk("t2_done_cnt", done_cnt, 1);

    // Write ready withheld for 10 cycles.
    clear_log();
    num_tiles = 1; wr_base = 64'h5000; rd_base = 64'h7000;
    axi_write_start_ready = 1'b0;
    pulse_start();
    repeat (10) step();
    chk("t3_held", wr_q.size() + rd_q.size(), 0);
    axi_write_start_ready = 1'b1;
    #1;
    chk("t3_fire_on_ready", init_write, 1);
    wait_done(100, ok);
    chk("t3_done_seen", ok, 1);
    step();
    if (wr_q.size() == 1 && rd_q.size() == 1) begin
      chk("t3_wr_addr", wr_q[0], 64'h5000);
      chk("t3_rd_addr", rd_q[0], 64'h7000);
    end
    chk("t3_order", order_bits, 64'b101);

    // Restart and descriptor changes mid-job are ignored.
    clear_log();
    num_tiles = 2; rd_base = 64'h100000; rd_stride = 64'h40;
    wr_base = 64'h200000; wr_stride = 64'h80; tile_rd_len = 32'h300;
    axi_dma_rd_idle = 1'b0;
    pulse_start();
    repeat (6) step();
    rd_base = 64'hdead000; wr_base = 64'hbeef000; rd_stride = 64'h4;
    wr_stride = 64'h4; num_tiles = 7; tile_rd_len = 32'h999;
    pulse_start();
    repeat (20) step();
    chk("t4_wait_on_idle", wr_q.size(), 1);
    axi_dma_rd_idle = 1'b1;
    wait_done(200, ok);
    chk("t4_done_seen", ok, 1);
    chk("t4_tiles", tiles_done, 2);
    repeat (20) step();
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_rd_cnt", rd_q.size(), 2);
    if (rd_q.size() == 2 && wr_q.size() == 2) begin
      chk("t4_rd1", rd_q[1], 64'h100040);
      chk("t4_wr1", wr_q[1], 64'h200080);
      chk("t4_rlen1", rlen_q[1], 32'h300);
    end

    // Address wrap-around.
    clear_log();
    num_tiles = 2; rd_base = 64'hFFFF_FFFF_FFFF_F000; rd_stride = 64'h1000;
    wr_base = 64'h0; wr_stride = 64'h1000;
    pulse_start();
    wait_done(200, ok);
    chk("t5_done_seen", ok, 1);
    chk("t5_error", error, 0);
    step();
    if (rd_q.size() == 2) begin
      chk("t5_rd0", rd_q[0], 64'hFFFF_FFFF_FFFF_F000);
      chk("t5_rd1", rd_q[1], 64'h0);
    end

    // Reset while waiting for idle.
    clear_log();
    num_tiles = 3; rd_base = 64'h4000; wr_base = 64'h8000;
    axi_dma_rd_idle = 1'b0;
    pulse_start();
    repeat (10) step();
    chk("t6_busy_pre", busy, 1);
    rstn = 1'b0;
    step();
    chk("t6_busy", busy, 0);
    chk("t6_init", {init_write, init_read}, 0);
    chk("t6_addr", axi_read_start_addr | axi_write_start_addr, 0);
    chk("t6_len", {axi_read_length, axi_write_length}, 0);
    chk("t6_tiles", tiles_done, 0);
    chk("t6_done", {done, error}, 0);
    rstn = 1'b1;
    axi_dma_rd_idle = 1'b1;
    repeat (20) step();
    chk("t6_no_more_cmds", wr_q.size(), 1);
    chk("t6_no_done", done_cnt, 0);

    chk("protocol_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
